// File: rtl/ev22_pkg.sv
// Shared EV22 types and constants for the W-register memory port.
package ev22_pkg;

    localparam int EV22_DATA_W = 16;
    localparam int EV22_ADDR_W = 12;
    localparam int EV22_W_SEL  = 34;   // W register code on the B/C buses

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } wmem_state_t;

endpackage

// File: rtl/wmem_timeout_cnt.sv
// Wait-cycle counter for w_mem_port; flags the cycle on which the wait limit is hit.
module wmem_timeout_cnt #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic busy_i,     // in RD or WR
    input  logic ready_i,    // memory completes this cycle
    output logic hit_o       // this is the TIMEOUT_CYC-th cycle without ready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter idles at zero outside an access, so it is clear on entry.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy_i)
            cnt_d = '0;
        else if (!ready_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign hit_o = busy_i && !ready_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/w_mem_port.sv
// Memory-side initiator for the EV22 W register: performs data RAM reads into W
// and writes of W, stalling the control unit. Optional macro: WMEM_TIMEOUT_EN.
module w_mem_port
    import ev22_pkg::*;
#(
    parameter int ADDR_W      = EV22_ADDR_W,
    parameter int DATA_W      = EV22_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mr_req,
    input  logic              mw_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              stall,
    output logic [DATA_W-1:0] w_in,
    output logic              mr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    wmem_state_t       state_q;
    logic [DATA_W-1:0] w_in_q;
    logic              mr_q, mem_re_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              busy;
    logic              to_hit;

    assign busy = (state_q == RD) || (state_q == WR);

`ifdef WMEM_TIMEOUT_EN
    logic err_q;

    wmem_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_to_cnt (
        .clk     (clk),
        .reset   (reset),
        .busy_i  (busy),
        .ready_i (mem_ready),
        .hit_o   (to_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (to_hit)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign to_hit         = 1'b0;
    assign err            = 1'b0;
`endif

    // Same-cycle freeze on a new request; held through the whole access.
    assign stall = (state_q == IDLE) ? (mr_req | mw_req) : busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            w_in_q      <= '0;
            mr_q        <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mr_q <= 1'b0;
                    // Write wins a simultaneous request; the read is dropped.
                    if (mw_req) begin
                        mem_addr_q  <= addr;
                        mem_wdata_q <= w_data;
                        mem_we_q    <= 1'b1;
                        state_q     <= WR;
                    end else if (mr_req) begin
                        mem_addr_q <= addr;
                        mem_re_q   <= 1'b1;
                        state_q    <= RD;
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        w_in_q   <= mem_rdata;
                        mr_q     <= 1'b1;
                        mem_re_q <= 1'b0;
                        state_q  <= DONE;
                    end else if (to_hit) begin
                        w_in_q   <= '1;
                        mr_q     <= 1'b1;
                        mem_re_q <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                WR: begin
                    if (mem_ready || to_hit) begin
                        mem_we_q <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    mr_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_in      = w_in_q;
    assign mr        = mr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_w_mem_port.sv
// Directed self-checking bench for w_mem_port; inputs change on the falling edge.
module tb_w_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr_req, mw_req;
    logic [11:0] addr;
    logic [15:0] w_data;
    logic        stall;
    logic [15:0] w_in;
    logic        mr, mem_re, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    w_mem_port #(.ADDR_W(12), .DATA_W(16), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset), .mr_req(mr_req), .mw_req(mw_req),
        .addr(addr), .w_data(w_data), .stall(stall), .w_in(w_in), .mr(mr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; mr_req = 0; mw_req = 0; addr = 0; w_data = 0;
        mem_rdata = 0; mem_ready = 0;
        tick; #1;
        nvec++; if ({stall, mr, mem_re, mem_we, err} !== 5'b0) begin
            nfail++; $display("FAIL reset_ctl got %b want 00000", {stall, mr, mem_re, mem_we, err}); end
        nvec++; if ({w_in, mem_addr, mem_wdata} !== 44'h0) begin
            nfail++; $display("FAIL reset_data got %h want 0", {w_in, mem_addr, mem_wdata}); end
        reset = 1'b0;
        // start a read and kill it with reset while in RD
        mr_req = 1; addr = 12'h03C; #1;
        nvec++; if (stall !== 1'b1) begin nfail++; $display("FAIL rst_req_stall got %b want 1", stall); end
        tick; #1;
        nvec++; if (mem_re !== 1'b1) begin nfail++; $display("FAIL rst_rd_re got %b want 1", mem_re); end
        reset = 1'b1; #1;
        nvec++; if ({mr, mem_re, mem_we, mem_addr} !== 15'h0) begin
            nfail++; $display("FAIL midrd_reset got %h want 0", {mr, mem_re, mem_we, mem_addr}); end
        nvec++; if (stall !== 1'b1) begin nfail++; $display("FAIL midrd_stall_req got %b want 1", stall); end
        mr_req = 0; #1;
        nvec++; if (stall !== 1'b0) begin nfail++; $display("FAIL midrd_stall_idle got %b want 0", stall); end
        tick; reset = 1'b0; tick; #1;
        nvec++; if ({mr, mem_re, w_in} !== 18'h0) begin
            nfail++; $display("FAIL post_reset got %h want 0", {mr, mem_re, w_in}); end
    endtask

    task automatic test_zero_wait_read;
        mr_req = 1; addr = 12'h05A; #1;
        nvec++; if (stall !== 1'b1) begin nfail++; $display("FAIL zr_stall_n got %b want 1", stall); end
        tick;
        mem_ready = 1; mem_rdata = 16'hBEEF; addr = 12'h777; #1;
        nvec++; if ({stall, mem_re, mem_we} !== 3'b110) begin
            nfail++; $display("FAIL zr_rd_ctl got %b want 110", {stall, mem_re, mem_we}); end
        nvec++; if (mem_addr !== 12'h05A) begin nfail++; $display("FAIL zr_addr got %h want 05a", mem_addr); end
        tick;
        mem_ready = 0; mem_rdata = 16'h0000; #1;
        nvec++; if ({stall, mr, mem_re} !== 3'b010) begin
            nfail++; $display("FAIL zr_done_ctl got %b want 010", {stall, mr, mem_re}); end
        nvec++; if (w_in !== 16'hBEEF) begin nfail++; $display("FAIL zr_w_in got %h want beef", w_in); end
        mr_req = 0;
        tick; #1;
        nvec++; if ({stall, mr} !== 2'b00) begin nfail++; $display("FAIL zr_idle got %b want 00", {stall, mr}); end
        // mem_ready in IDLE must not disturb anything
        mem_ready = 1; mem_rdata = 16'h1111;
        tick; mem_ready = 0; #1;
        nvec++; if ({w_in, mr, mem_re} !== {16'hBEEF, 2'b00}) begin
            nfail++; $display("FAIL idle_ready got %h/%b want beef/00", w_in, {mr, mem_re}); end
    endtask

    task automatic test_wait_write;
        int we_cnt = 0;
        int mr_seen = 0;
        mw_req = 1; addr = 12'h100; w_data = 16'h1234;
        tick;
        for (int c = 1; c <= 4; c++) begin
            if (c == 1) w_data = 16'hFFFF;
            mem_ready = (c == 4); #1;
            if (mem_we) we_cnt++;
            if (mr) mr_seen++;
            nvec++; if ({stall, mem_wdata, mem_addr} !== {1'b1, 16'h1234, 12'h100}) begin
                nfail++; $display("FAIL ww_hold c%0d got %b/%h/%h want 1/1234/100", c, stall, mem_wdata, mem_addr); end
            tick;
        end
        mem_ready = 0; #1;
        nvec++; if (we_cnt !== 4) begin nfail++; $display("FAIL ww_we_cycles got %0d want 4", we_cnt); end
        nvec++; if ({stall, mr, mem_we, mr_seen[0]} !== 4'b0000) begin
            nfail++; $display("FAIL ww_done got %b want 0000", {stall, mr, mem_we, mr_seen[0]}); end
        mw_req = 0; tick;
    endtask

    task automatic test_simultaneous;
        mr_req = 1; mw_req = 1; addr = 12'h2A0; w_data = 16'hC0DE;
        tick; mem_ready = 1; #1;
        nvec++; if ({mem_re, mem_we} !== 2'b01) begin
            nfail++; $display("FAIL sim_en got %b want 01", {mem_re, mem_we}); end
        tick; mem_ready = 0; #1;
        nvec++; if ({mr, mem_re, stall} !== 3'b000) begin
            nfail++; $display("FAIL sim_done got %b want 000", {mr, mem_re, stall}); end
        mr_req = 0; mw_req = 0; tick; #1;
        nvec++; if ({mem_re, mr, w_in} !== {2'b00, 16'hBEEF}) begin
            nfail++; $display("FAIL sim_no_replay got %b/%h want 00/beef", {mem_re, mr}, w_in); end
    endtask

    task automatic test_back_to_back;
        mr_req = 1; addr = 12'h010;
        tick; mem_ready = 1; mem_rdata = 16'hA5A5;
        tick; mem_ready = 0; #1;
        nvec++; if ({mr, w_in} !== {1'b1, 16'hA5A5}) begin
            nfail++; $display("FAIL b2b_rd got %b/%h want 1/a5a5", mr, w_in); end
        // next instruction's write presented immediately
        mr_req = 0; mw_req = 1; addr = 12'h020; w_data = 16'h5555;
        tick; #1;
        nvec++; if ({mr, mem_re, mem_we, stall} !== 4'b0001) begin
            nfail++; $display("FAIL b2b_idle got %b want 0001", {mr, mem_re, mem_we, stall}); end
        tick; mem_ready = 1; #1;
        nvec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h020, 16'h5555}) begin
            nfail++; $display("FAIL b2b_wr got %b/%h/%h want 1/020/5555", mem_we, mem_addr, mem_wdata); end
        tick; mem_ready = 0; mw_req = 0; #1;
        nvec++; if ({mr, w_in, err} !== {1'b0, 16'hA5A5, 1'b0}) begin
            nfail++; $display("FAIL b2b_done got %b/%h/%b want 0/a5a5/0", mr, w_in, err); end
        tick;
    endtask

`ifdef WMEM_TIMEOUT_EN
    task automatic test_timeout;
        int re_cnt = 0;
        mr_req = 1; addr = 12'h0F0; mem_ready = 0;
        tick;
        for (int c = 1; c <= 4; c++) begin
            #1; if (mem_re) re_cnt++;
            tick;
        end
        #1;
        nvec++; if (re_cnt !== 4) begin nfail++; $display("FAIL to_re_cycles got %0d want 4", re_cnt); end
        nvec++; if ({mr, err, stall, w_in} !== {3'b110, 16'hFFFF}) begin
            nfail++; $display("FAIL to_done got %b/%h want 110/ffff", {mr, err, stall}, w_in); end
        mr_req = 0; tick; tick; #1;
        nvec++; if ({err, mr} !== 2'b10) begin nfail++; $display("FAIL to_sticky got %b want 10", {err, mr}); end
        reset = 1; #1;
        nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL to_reset_err got %b want 0", err); end
        tick; reset = 0; tick;
    endtask
`endif

    initial begin
        test_reset;
        test_zero_wait_read;
        test_wait_write;
        test_simultaneous;
        test_back_to_back;
`ifdef WMEM_TIMEOUT_EN
        test_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/w_mem_port.md
Name: w_mem_port

Overview:
- Memory-side initiator for the EV22 working register (W).
- The register bank only consumes MR/W_IN and exposes Working_Reg. This block performs the actual data-memory read and write transactions.
- Read: fetches memory, drives w_in, pulses mr so the bank loads W.
- Write: sends w_data (Working_Reg) to memory.
- Stalls the control unit until each transaction completes.
- Sits between the control unit / register bank and a synchronous data RAM with a ready handshake.

Parameters:
ADDR_W, 12, data-memory address width
DATA_W, 16, data / W register width
TIMEOUT_CYC, 255, wait-cycle limit (used only with WMEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
mr_req  in  1  control unit requests memory read into W (level)
mw_req  in  1  control unit requests write of W to memory (level)
addr  in  ADDR_W  memory address for the request
w_data  in  DATA_W  current Working_Reg value
stall  out  1  control unit must hold state while high
w_in  out  DATA_W  read data toward register bank W_IN
mr  out  1  one-cycle load strobe to register bank MR
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1 in RD
mem_ready  in  1  memory completes current access this cycle
err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset values (async, any state): IDLE; w_in=0, mr=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0.
- IDLE: stall = mr_req | mw_req (combinational, same-cycle freeze). mr=0, mem_re=0, mem_we=0.
  - mw_req=1 → capture addr→mem_addr, w_data→mem_wdata; go to WR.
  - else mr_req=1 → capture addr; go to RD.
  - mr_req & mw_req together: write wins, read is discarded (not replayed).
- RD: mem_re=1, mem_addr held, stall=1.
  - On mem_ready=1: w_in <= mem_rdata; go to DONE.
- WR: mem_we=1, mem_addr and mem_wdata held, stall=1.
  - On mem_ready=1: go to DONE.
- DONE: stall=0. mr=1 only if the completed access was a read. mem_re=mem_we=0. Next state IDLE unconditionally.
  - Control unit advances in DONE. Requests seen in the following IDLE belong to the next instruction.
- Latency, zero-wait memory: accept cycle N, access N+1, DONE N+2. stall high for N and N+1. Each memory wait cycle adds one.
- w_in holds its value until the next read completes. mr is registered with no glitches.
- addr/w_data changes after acceptance are ignored (captured copies are used).
- mem_ready in IDLE or DONE is ignored.
- Reset mid-transaction: enables drop asynchronously, access aborted, no mr pulse.

Optional Feature:
WMEM_TIMEOUT_EN
- Defined:
  - Wait counter clears on entering RD/WR and increments each cycle without mem_ready.
  - If it reaches TIMEOUT_CYC: go to DONE and set err=1 (sticky until reset).
  - Timed-out read: w_in <= all ones; mr still pulses.
  - Timed-out write: dropped.
  - mem_ready on the same cycle as the timeout wins (normal completion).
- Undefined: waits indefinitely; err tied 0; no counter logic.

Decomposition:
- Package ev22_pkg: wmem_state_t enum (IDLE, RD, WR, DONE), EV22_DATA_W=16, EV22_ADDR_W, EV22_W_SEL=34 (W code on B/C buses).
- One natural sub-module: wmem_timeout_cnt (counter + compare, instantiated only under WMEM_TIMEOUT_EN).

Test Plan:
- Reset: assert reset mid-RD → all outputs 0, state IDLE, stall follows requests only.
- Zero-wait read:
  - Stimulus: mr_req=1, addr=12'h05A; mem_ready=1 in RD with mem_rdata=16'hBEEF.
  - Required: stall=1 for 2 cycles; DONE: mr=1, w_in=16'hBEEF, stall=0.
- Wait-state write:
  - Stimulus: mw_req=1, addr=12'h100, w_data=16'h1234; mem_ready after 3 waits; change w_data in cycle 1.
  - Required: mem_we=1 for 4 cycles, mem_wdata stays 16'h1234, no mr pulse.
- Simultaneous mr_req=mw_req=1 → WR only, mem_re never asserted, mr=0.
- Back-to-back: read then write on consecutive instructions → IDLE between them, second access addr/data correct.
- WMEM_TIMEOUT_EN, TIMEOUT_CYC=4, read with mem_ready=0 → DONE after 4 wait cycles, w_in=16'hFFFF, mr=1, err=1 until reset.
